// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the divider sequencing controller.
package div_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FAST  = 3'd1,
    ST_HIT   = 3'd2,
    ST_BUSY  = 3'd3,
    ST_WB    = 3'd4,
    ST_ABORT = 3'd5
  } div_state_t;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [DIV_XLEN-1:0] SIGNED_MIN    = 32'h8000_0000;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage request/write-back bus plus the divider core handshake.
interface div_ctrl_if #(parameter int XLEN = 32);

  logic              req_valid_i;
  logic [1:0]        req_op_i;
  logic [XLEN-1:0]   req_rs1_i;
  logic [XLEN-1:0]   req_rs2_i;
  logic [4:0]        req_rd_i;
  logic              flush_i;
  logic              busy_o;
  logic              wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;
  logic              div_start_o;
  logic              div_signed_o;
  logic [XLEN-1:0]   div_dividend_o;
  logic [XLEN-1:0]   div_divisor_o;
  logic              div_ready_i;
  logic [2*XLEN-1:0] div_result_i;

  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           div_ready_i, div_result_i,
    output busy_o, wb_valid_o, wb_rd_o, wb_data_o,
           div_start_o, div_signed_o, div_dividend_o, div_divisor_o
  );

  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           div_ready_i, div_result_i,
    input  busy_o, wb_valid_o, wb_rd_o, wb_data_o,
           div_start_o, div_signed_o, div_dividend_o, div_divisor_o
  );

endinterface

// File: rtl/div_result_cache.sv
// Single-entry cache of the last core result, keyed on operands and signedness.
module div_result_cache #(
  parameter int XLEN   = 32,
  parameter bit ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] cmp_rs1,
  input  logic [XLEN-1:0] cmp_rs2,
  input  logic            cmp_signed,
  output logic            hit,
  output logic [XLEN-1:0] hit_quot,
  output logic [XLEN-1:0] hit_rem,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic            wr_signed,
  input  logic [XLEN-1:0] wr_quot,
  input  logic [XLEN-1:0] wr_rem
);

  logic            valid_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic            signed_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      signed_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      rs1_q    <= wr_rs1;
      rs2_q    <= wr_rs2;
      signed_q <= wr_signed;
      quot_q   <= wr_quot;
      rem_q    <= wr_rem;
    end
  end

  assign hit = ENABLE && valid_q && (cmp_rs1 == rs1_q) && (cmp_rs2 == rs2_q)
               && (cmp_signed == signed_q);
  assign hit_quot = quot_q;
  assign hit_rem  = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Sequences RV32M divide/remainder requests onto the iterative divider core,
// short-circuiting divide-by-zero, signed overflow and repeated operands.
//
// state | meaning
// IDLE  | waiting for a request; classifies it on accept
// FAST  | divide-by-zero or signed overflow, result formed locally
// HIT   | operands match the cached core result
// BUSY  | core running, start held until ready
// WB    | one-cycle write-back pulse
// ABORT | flushed core run; the core's trailing ready is swallowed here
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] QUOT_DIV0 = {XLEN{DIV_ZERO_QUOT[0]}};
  localparam logic [XLEN-1:0] MIN_NEG   = {SIGNED_MIN[DIV_XLEN-1], {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  div_op_t         op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic            signed_q;
  logic [XLEN-1:0] wb_data_q;

  div_op_t         req_op;
  logic            req_signed;
  logic            req_fast;
  logic            accept;
  logic            cache_hit;
  logic [XLEN-1:0] cache_quot;
  logic [XLEN-1:0] cache_rem;
  logic            cache_wr;
  logic            load_wb;
  logic [XLEN-1:0] wb_next;
  logic            start;
  logic            wb_valid;
  logic [XLEN-1:0] fast_quot;
  logic [XLEN-1:0] fast_rem;
  logic [XLEN-1:0] core_quot;
  logic [XLEN-1:0] core_rem;

  assign req_op     = div_op_t'(bus.req_op_i);
  assign req_signed = op_is_signed(req_op);
  assign req_fast   = (bus.req_rs2_i == '0) ||
                      (req_signed && (bus.req_rs1_i == MIN_NEG) && (bus.req_rs2_i == QUOT_DIV0));
  assign accept     = (state_q == ST_IDLE) && bus.req_valid_i && !bus.flush_i;

  // FAST is only entered for these two cases, so divisor==0 alone picks between them.
  assign fast_quot = (rs2_q == '0) ? QUOT_DIV0 : MIN_NEG;
  assign fast_rem  = (rs2_q == '0) ? rs1_q : '0;
  assign core_quot = bus.div_result_i[XLEN-1:0];
  assign core_rem  = bus.div_result_i[2*XLEN-1:XLEN];

  div_result_cache #(
    .XLEN   (XLEN),
    .ENABLE (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .rst        (rst),
    .cmp_rs1    (bus.req_rs1_i),
    .cmp_rs2    (bus.req_rs2_i),
    .cmp_signed (req_signed),
    .hit        (cache_hit),
    .hit_quot   (cache_quot),
    .hit_rem    (cache_rem),
    .wr_en      (cache_wr),
    .wr_rs1     (rs1_q),
    .wr_rs2     (rs2_q),
    .wr_signed  (signed_q),
    .wr_quot    (core_quot),
    .wr_rem     (core_rem)
  );

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    wb_valid = 1'b0;
    load_wb  = 1'b0;
    wb_next  = '0;
    cache_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_fast)       state_d = ST_FAST;
          else if (cache_hit) state_d = ST_HIT;
          else                state_d = ST_BUSY;
        end
      end
      ST_FAST: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          load_wb = 1'b1;
          wb_next = op_is_rem(op_q) ? fast_rem : fast_quot;
          state_d = ST_WB;
        end
      end
      ST_HIT: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          load_wb = 1'b1;
          wb_next = op_is_rem(op_q) ? cache_rem : cache_quot;
          state_d = ST_WB;
        end
      end
      ST_BUSY: begin
        // Start drops combinationally with ready so the core never re-launches.
        start = !bus.div_ready_i && !bus.flush_i;
        if (bus.flush_i) begin
          state_d = ST_ABORT;
        end else if (bus.div_ready_i) begin
          cache_wr = 1'b1;
          load_wb  = 1'b1;
          wb_next  = op_is_rem(op_q) ? core_rem : core_quot;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid = !bus.flush_i;
        state_d  = ST_IDLE;
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= DIV_OP_DIV;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      signed_q  <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_op;
        rd_q     <= bus.req_rd_i;
        rs1_q    <= bus.req_rs1_i;
        rs2_q    <= bus.req_rs2_i;
        signed_q <= req_signed;
      end
      if (load_wb) begin
        wb_data_q <= wb_next;
      end
    end
  end

  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.wb_valid_o     = wb_valid;
  assign bus.wb_rd_o        = rd_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.div_start_o    = start;
  assign bus.div_signed_o   = signed_q;
  assign bus.div_dividend_o = rs1_q;
  assign bus.div_divisor_o  = rs2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider core, RV32M reference arithmetic and a
// one-entry model of which operand pairs should be answered without the core.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if #(.XLEN(32)) dif ();

  div_ctrl #(.XLEN(32), .CACHE_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  int total = 0;
  int bad   = 0;
  int lat_cfg = 3;

  logic        m_valid = 1'b0;
  logic [31:0] m_a, m_b;
  logic        m_s;

  function automatic logic [63:0] ref_pair(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = ONES; r = a;
    end else if (s && a == MINV && b == ONES) begin
      q = MINV; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = ref_pair(a, b, ~op[0]);
    return op[1] ? p[63:32] : p[31:0];
  endfunction

  // Divider core: fixed latency after sampling start, zero-result ready when abandoned.
  logic        c_busy;
  int          c_cnt;
  logic [31:0] c_a, c_b;
  logic        c_s;
  always @(posedge clk) begin
    if (rst) begin
      c_busy           <= 1'b0;
      c_cnt            <= 0;
      dif.div_ready_i  <= 1'b0;
      dif.div_result_i <= '0;
    end else begin
      dif.div_ready_i  <= 1'b0;
      dif.div_result_i <= '0;
      if (!c_busy) begin
        if (dif.div_start_o) begin
          c_busy <= 1'b1;
          c_cnt  <= lat_cfg;
          c_a    <= dif.div_dividend_o;
          c_b    <= dif.div_divisor_o;
          c_s    <= dif.div_signed_o;
        end
      end else if (!dif.div_start_o) begin
        c_busy          <= 1'b0;
        dif.div_ready_i <= 1'b1;
      end else if (c_cnt == 0) begin
        c_busy           <= 1'b0;
        dif.div_ready_i  <= 1'b1;
        dif.div_result_i <= ref_pair(c_a, c_b, c_s);
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dif.div_ready_i) begin
      total++;
      if (dif.div_start_o !== 1'b0) begin
        bad++;
        $display("FAIL start_with_ready: div_start_o=%b while ready high, want 0", dif.div_start_o);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (dif.busy_o && g < 100) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic        exp_s, fast, hit, got;
    logic [31:0] exp;
    int          n, starts;
    exp_s = ~op[0];
    exp   = ref_data(op, a, b);
    fast  = (b == 32'd0) || (exp_s && a == MINV && b == ONES);
    hit   = !fast && m_valid && m_a == a && m_b == b && m_s == exp_s;
    wait_idle();
    dif.req_valid_i = 1'b1;
    dif.req_op_i    = op;
    dif.req_rs1_i   = a;
    dif.req_rs2_i   = b;
    dif.req_rd_i    = rd;
    @(negedge clk);
    dif.req_valid_i = 1'b0;
    total++;
    if (dif.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: busy_o=%b want 1", tag, dif.busy_o);
    end
    n = 1; starts = 0; got = 1'b0;
    while (n < 200) begin
      if (dif.wb_valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (dif.div_start_o === 1'b1) begin
        starts++;
        total++;
        if ({dif.div_dividend_o, dif.div_divisor_o, dif.div_signed_o} !== {a, b, exp_s}) begin
          bad++;
          $display("FAIL %s core_operands: got %h/%h s=%b want %h/%h s=%b", tag,
                   dif.div_dividend_o, dif.div_divisor_o, dif.div_signed_o, a, b, exp_s);
        end
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s wb_timeout: no wb_valid_o within %0d cycles", tag, n);
    end else begin
      total++;
      if (dif.wb_data_o !== exp || dif.wb_rd_o !== rd) begin
        bad++;
        $display("FAIL %s wb: data=%h rd=%0d want data=%h rd=%0d", tag, dif.wb_data_o,
                 dif.wb_rd_o, exp, rd);
      end
      total++;
      if (fast || hit) begin
        if (n != 2 || starts != 0) begin
          bad++;
          $display("FAIL %s latency_local: lat=%0d starts=%0d want lat=2 starts=0", tag, n, starts);
        end
      end else if (starts == 0 || n != starts + 2) begin
        bad++;
        $display("FAIL %s latency_core: lat=%0d starts=%0d want lat=starts+2 starts>0", tag, n, starts);
      end
      if (!fast && !hit) begin
        m_valid = 1'b1; m_a = a; m_b = b; m_s = exp_s;
      end
    end
    @(negedge clk);
    total++;
    if (dif.wb_valid_o !== 1'b0 || dif.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse_end: wb_valid_o=%b busy_o=%b want 0 0", tag, dif.wb_valid_o, dif.busy_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({dif.busy_o, dif.wb_valid_o, dif.div_start_o} !== 3'b000 ||
        dif.wb_rd_o !== 5'd0 || dif.wb_data_o !== 32'd0) begin
      bad++;
      $display("FAIL %s: busy=%b wbv=%b start=%b rd=%0d data=%h want all 0", tag, dif.busy_o,
               dif.wb_valid_o, dif.div_start_o, dif.wb_rd_o, dif.wb_data_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_cache_pair();
    lat_cfg = 4;
    run_op(2'd0, 32'd100, 32'd7, 5'd11, "div_100_7");
    run_op(2'd2, 32'd100, 32'd7, 5'd12, "rem_100_7_hit");
  endtask

  task automatic test_fast();
    run_op(2'd1, 32'd5, 32'd0, 5'd1, "divu_by_zero");
    run_op(2'd3, 32'd5, 32'd0, 5'd2, "remu_by_zero");
    run_op(2'd0, 32'hFFFF_FFEC, 32'd0, 5'd3, "div_signed_by_zero");
    run_op(2'd0, MINV, ONES, 5'd4, "div_overflow");
    run_op(2'd2, MINV, ONES, 5'd5, "rem_overflow");
  endtask

  task automatic test_signed();
    lat_cfg = 6;
    run_op(2'd0, 32'hFFFF_FFEC, 32'd3, 5'd6, "div_m20_3");
    run_op(2'd2, 32'hFFFF_FFEC, 32'd3, 5'd7, "rem_m20_3");
    run_op(2'd1, 32'hFFFF_FFEC, 32'd3, 5'd8, "divu_m20_3");
  endtask

  task automatic test_flush();
    int wbs = 0;
    lat_cfg = 12;
    wait_idle();
    dif.req_valid_i = 1'b1;
    dif.req_op_i    = 2'd0;
    dif.req_rs1_i   = 32'd1234567;
    dif.req_rs2_i   = 32'd89;
    dif.req_rd_i    = 5'd9;
    @(negedge clk);
    dif.req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (dif.div_start_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre: div_start_o=%b want 1", dif.div_start_o);
    end
    dif.flush_i = 1'b1;
    #1;
    total++;
    if (dif.div_start_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_drop: div_start_o=%b want 0", dif.div_start_o);
    end
    @(negedge clk);
    dif.flush_i = 1'b0;
    total++;
    if (dif.busy_o !== 1'b1 || dif.wb_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_abort: busy_o=%b wb_valid_o=%b want 1 0", dif.busy_o, dif.wb_valid_o);
    end
    @(negedge clk);
    total++;
    if (dif.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_abort_len: busy_o=%b want 0", dif.busy_o);
    end
    repeat (6) begin
      if (dif.wb_valid_o !== 1'b0) wbs++;
      @(negedge clk);
    end
    total++;
    if (wbs != 0) begin
      bad++;
      $display("FAIL flush_no_wb: wb pulses=%0d want 0", wbs);
    end
    lat_cfg = 3;
    run_op(2'd0, 32'd9, 32'd3, 5'd10, "div_9_3_after_flush");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    lat_cfg = 2;
    wait_idle();
    dif.req_valid_i = 1'b1;
    dif.req_op_i    = 2'd0;
    dif.req_rs1_i   = 32'd50;
    dif.req_rs2_i   = 32'd0;
    dif.req_rd_i    = 5'd3;
    @(negedge clk);
    dif.req_op_i  = 2'd1;
    dif.req_rs1_i = 32'd77;
    dif.req_rs2_i = 32'd5;
    dif.req_rd_i  = 5'd4;
    while (dif.wb_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dif.wb_valid_o !== 1'b1 || dif.wb_data_o !== ONES || dif.wb_rd_o !== 5'd3) begin
      bad++;
      $display("FAIL b2b_first: wbv=%b data=%h rd=%0d want 1 %h 3", dif.wb_valid_o,
               dif.wb_data_o, dif.wb_rd_o, ONES);
    end
    @(negedge clk);
    total++;
    if (dif.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: busy_o=%b want 0", dif.busy_o);
    end
    @(negedge clk);
    dif.req_valid_i = 1'b0;
    total++;
    if (dif.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_accept: busy_o=%b want 1", dif.busy_o);
    end
    n = 0;
    while (dif.wb_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dif.wb_valid_o !== 1'b1 || dif.wb_data_o !== 32'd15 || dif.wb_rd_o !== 5'd4) begin
      bad++;
      $display("FAIL b2b_second: wbv=%b data=%h rd=%0d want 1 0000000f 4", dif.wb_valid_o,
               dif.wb_data_o, dif.wb_rd_o);
    end
    m_valid = 1'b1; m_a = 32'd77; m_b = 32'd5; m_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    lat_cfg = 10;
    wait_idle();
    dif.req_valid_i = 1'b1;
    dif.req_op_i    = 2'd0;
    dif.req_rs1_i   = 32'd555;
    dif.req_rs2_i   = 32'd11;
    dif.req_rd_i    = 5'd13;
    @(negedge clk);
    dif.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_busy");
    rst = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    lat_cfg = 2;
    run_op(2'd2, 32'd77, 32'd5, 5'd14, "rem_after_reset_nohit");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd7;
      3:       return MINV;
      4:       return ONES;
      5:       return 32'hFFFF_FFEC;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b;
    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) >= 4) begin
        a = pick();
        b = pick();
      end
      lat_cfg = $urandom_range(0, 6);
      run_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), "random");
    end
  endtask

  initial begin
    dif.req_valid_i = 1'b0;
    dif.req_op_i    = 2'd0;
    dif.req_rs1_i   = 32'd0;
    dif.req_rs2_i   = 32'd0;
    dif.req_rd_i    = 5'd0;
    dif.flush_i     = 1'b0;
    test_reset();
    test_cache_pair();
    test_fast();
    test_signed();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
